captura_entrada: RTL and testbench
==================================

Name: captura_entrada

Overview:
- Upstream front-end for the 4-bit encoder/display stage.
- Samples four raw switches and a raw "confirm" push-button, synchronises and debounces the button, and captures one switch value per clean press.
- Presents the captured value on Input with a one-cycle Ready strobe, the exact pair the encoder consumes.
- Rejects non-BCD values (>9) with an Error strobe instead of Ready.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable synchronised-button cycles required to accept a press or a release (5 ms at 50 MHz); legal range ≥2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width (derived, not overridden).

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Switches  in  4  raw asynchronous switch levels.
- Button  in  1  raw asynchronous confirm button, 1 = pressed.
- Input  out  4  last accepted BCD value; held until the next accepted capture.
- Ready  out  1  one-cycle pulse; Input is valid and new in the same cycle.
- Error  out  1  one-cycle pulse; captured value was >9 and was discarded.
- Busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, active-high) has priority over everything:
  - Input=0, Ready=0, Error=0, Busy=0, state=IDLE, counter=0, synchroniser flops=0.
  - Reset asserted mid-debounce or mid-hold aborts with no Ready/Error.
- Synchronisation:
  - Button and each Switches bit pass through a 2-flop synchroniser (btn_s, sw_s).
  - The FSM only sees btn_s and sw_s.
- FSM states: IDLE, DEB_PRESS, HELD, DEB_RELEASE.
  - IDLE: btn_s=1 -> DEB_PRESS, counter<=0.
  - DEB_PRESS: btn_s=0 -> IDLE (glitch rejected, no output).
  - DEB_PRESS: btn_s=1 and counter<DEBOUNCE_CYCLES-1 -> counter+1.
  - DEB_PRESS: btn_s=1 and counter==DEBOUNCE_CYCLES-1 -> capture sw_s, -> HELD.
  - HELD: btn_s=0 -> DEB_RELEASE, counter<=0. Holding the button never re-triggers.
  - DEB_RELEASE: btn_s=1 -> HELD (bounce on release).
  - DEB_RELEASE: btn_s=0 and counter==DEBOUNCE_CYCLES-1 -> IDLE; otherwise counter+1.
- Capture edge:
  - If sw_s≤9: Input<=sw_s and Ready<=1 on the same edge.
  - Otherwise: Error<=1 and Input unchanged.
  - Ready and Error are never high together.
  - Both are cleared on the following edge (exactly one cycle wide).
- Latency: raw Button high from edge 0 and held -> Ready/Error high after edge DEBOUNCE_CYCLES+3 (2 sync + 1 entry + DEBOUNCE_CYCLES count).
- Switch value used is sw_s at the capture edge. Switch changes during HELD are ignored.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap.
- Busy is combinational: (state != IDLE).

Decomposition:
- Shared package entrada_pkg:
  - state enum {IDLE, DEB_PRESS, HELD, DEB_RELEASE}.
  - constant BCD_MAX=4'd9.
- One sub-module, sync_2ff:
  - parameter WIDTH; synchronous active-high Reset to 0.
  - Instantiated once with WIDTH=5 for {Button, Switches}.

Test Plan (DEBOUNCE_CYCLES=4 for all):
- Reset, then Switches=4'd7, Button held high -> Ready=1 for exactly one cycle at edge 7, Input=7, Error=0, Busy=1 from edge 3.
- Button high for 3 cycles, then low -> no Ready/Error, FSM returns to IDLE, Input keeps its previous value.
- Switches=4'd12, clean press -> Error pulse at edge 7, Ready stays 0, Input keeps its prior value 7.
- Press accepted with value 3, release bouncing 1-0-1-0 within 4 cycles, then stable low, then a second press with value 5 -> exactly two Ready pulses, Input=3 then 5.
- Button held high for 100 cycles -> exactly one Ready pulse.
- Reset asserted at edge 5 of a valid press -> outputs 0 at the next edge, no Ready, Busy=0.

Source files
------------

// File: rtl/captura_entrada_pkg.sv
// Shared types and constants for the switch-capture front-end.
package entrada_pkg;

    // Button-handling FSM states
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        HELD        = 2'd2,
        DEB_RELEASE = 2'd3
    } state_t;

    // Largest value the downstream BCD encoder accepts
    localparam logic [3:0] BCD_MAX = 4'd9;

    // True when the nibble is a legal BCD digit
    function automatic logic is_bcd(input logic [3:0] value);
        return (value <= BCD_MAX);
    endfunction

endpackage

// File: rtl/captura_entrada_if.sv
// Switch/button inputs and captured-value outputs of the capture front-end.
interface captura_entrada_if;

    logic [3:0] Switches;
    logic       Button;
    logic [3:0] Input;
    logic       Ready;
    logic       Error;
    logic       Busy;

    // Side that drives the raw switches/button and consumes the result
    modport master (
        output Switches,
        output Button,
        input  Input,
        input  Ready,
        input  Error,
        input  Busy
    );

    // Side implemented by captura_entrada
    modport slave (
        input  Switches,
        input  Button,
        output Input,
        output Ready,
        output Error,
        output Busy
    );

endinterface

// File: rtl/captura_entrada_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, cleared by reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // First flop may go metastable; second flop gives it a full cycle to settle
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/captura_entrada.sv
// Debounces the confirm button and captures one switch value per clean press,
// presenting BCD values with a Ready strobe and rejecting others with Error.
module captura_entrada
    import entrada_pkg::*;
#(
    parameter  int DEBOUNCE_CYCLES = 250000,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic               Clock,
    input  logic               Reset,
    captura_entrada_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [4:0]       w_sync;
    logic             w_btn_s;
    logic [3:0]       w_sw_s;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_capture;

    logic [3:0]       r_input;
    logic             r_ready;
    logic             r_error;

    sync_2ff #(
        .WIDTH (5)
    ) u_sync (
        .i_clk  (Clock),
        .i_srst (Reset),
        .i_d    ({bus.Button, bus.Switches}),
        .o_q    (w_sync)
    );

    assign w_btn_s = w_sync[4];
    assign w_sw_s  = w_sync[3:0];

    // State, debounce counter and output registers; reset aborts any press in flight
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_input <= 4'd0;
            r_ready <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_ready <= w_capture && is_bcd(w_sw_s);
            r_error <= w_capture && !is_bcd(w_sw_s);
            if (w_capture && is_bcd(w_sw_s)) begin
                r_input <= w_sw_s;
            end
        end
    end

    // Next-state and counter logic; the counter saturates at CNT_LAST by construction
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_btn_s) begin
                    w_state_next = DEB_PRESS;
                    w_cnt_next   = '0;
                end
            end
            DEB_PRESS: begin
                if (!w_btn_s) begin
                    w_state_next = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = HELD;
                    w_capture    = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!w_btn_s) begin
                    w_state_next = DEB_RELEASE;
                    w_cnt_next   = '0;
                end
            end
            DEB_RELEASE: begin
                if (w_btn_s) begin
                    w_state_next = HELD;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign bus.Input = r_input;
    assign bus.Ready = r_ready;
    assign bus.Error = r_error;
    assign bus.Busy  = (r_state != IDLE);

endmodule

// File: tb/tb_captura_entrada.sv
// Directed bench for captura_entrada with DEBOUNCE_CYCLES=4.
module tb_captura_entrada;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   ready_cnt;
    int   error_cnt;
    int   both_cnt;
    int   wide_cnt;
    logic prev_ready;
    logic prev_error;

    captura_entrada_if bus ();

    captura_entrada #(
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor sampled on the falling edge, away from register updates
    always @(negedge clk) begin
        if (bus.Ready) ready_cnt++;
        if (bus.Error) error_cnt++;
        if (bus.Ready && bus.Error) both_cnt++;
        if ((bus.Ready && prev_ready) || (bus.Error && prev_error)) wide_cnt++;
        prev_ready = bus.Ready;
        prev_error = bus.Error;
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Advance n rising edges, landing 1 time unit after the last one
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] val, input int hold, input int low);
        bus.Switches = val;
        bus.Button   = 1'b1;
        step(hold);
        bus.Button   = 1'b0;
        step(low);
    endtask

    initial begin
        int r0;
        int e0;
        n_cmp = 0; n_bad = 0;
        ready_cnt = 0; error_cnt = 0; both_cnt = 0; wide_cnt = 0;
        prev_ready = 1'b0; prev_error = 1'b0;
        bus.Switches = 4'd0;
        bus.Button   = 1'b0;
        rst = 1'b1;
        step(3);
        check_val("rst_input", bus.Input, 0);
        check_val("rst_ready", bus.Ready, 0);
        check_val("rst_error", bus.Error, 0);
        check_val("rst_busy",  bus.Busy,  0);
        rst = 1'b0;
        step(2);

        // Clean press of 7: exact latency and strobe width
        bus.Switches = 4'd7;
        bus.Button   = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step(1);
            if (e == 2) check_val("t1_busy_e2", bus.Busy, 0);
            if (e == 3) check_val("t1_busy_e3", bus.Busy, 1);
            check_val($sformatf("t1_ready_e%0d", e), bus.Ready, (e == 7) ? 1 : 0);
            check_val($sformatf("t1_error_e%0d", e), bus.Error, 0);
            if (e == 7) check_val("t1_input_e7", bus.Input, 7);
        end
        bus.Button = 1'b0;
        step(12);
        check_val("t1_busy_idle", bus.Busy, 0);
        check_val("t1_ready_total", ready_cnt, 1);

        // Glitch: 3 cycles high is too short
        r0 = ready_cnt; e0 = error_cnt;
        bus.Switches = 4'd2;
        press(4'd2, 3, 12);
        check_val("t2_ready_none", ready_cnt - r0, 0);
        check_val("t2_error_none", error_cnt - e0, 0);
        check_val("t2_busy_idle",  bus.Busy, 0);
        check_val("t2_input_kept", bus.Input, 7);

        // Non-BCD 12: Error at edge 7, Input unchanged
        r0 = ready_cnt;
        bus.Switches = 4'd12;
        bus.Button   = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step(1);
            check_val($sformatf("t3_error_e%0d", e), bus.Error, (e == 7) ? 1 : 0);
        end
        bus.Button = 1'b0;
        step(12);
        check_val("t3_ready_none", ready_cnt - r0, 0);
        check_val("t3_input_kept", bus.Input, 7);

        // Press 3, bouncing release, then press 5
        r0 = ready_cnt;
        bus.Switches = 4'd3;
        bus.Button   = 1'b1;
        step(10);
        check_val("t4_input_3", bus.Input, 3);
        bus.Button = 1'b0; step(1);
        bus.Button = 1'b1; step(1);
        bus.Button = 1'b0; step(1);
        bus.Button = 1'b1; step(1);
        bus.Button = 1'b0; step(12);
        check_val("t4_busy_idle", bus.Busy, 0);
        check_val("t4_ready_one", ready_cnt - r0, 1);
        press(4'd5, 10, 12);
        check_val("t4_ready_two", ready_cnt - r0, 2);
        check_val("t4_input_5", bus.Input, 5);

        // Long hold with switch change while held
        r0 = ready_cnt;
        bus.Switches = 4'd6;
        bus.Button   = 1'b1;
        step(50);
        bus.Switches = 4'd2;
        step(50);
        bus.Button = 1'b0;
        step(12);
        check_val("t5_ready_one", ready_cnt - r0, 1);
        check_val("t5_input_6", bus.Input, 6);

        // BCD boundaries: 9 accepted, 10 rejected
        r0 = ready_cnt; e0 = error_cnt;
        press(4'd9, 10, 12);
        check_val("b9_ready", ready_cnt - r0, 1);
        check_val("b9_input", bus.Input, 9);
        press(4'd10, 10, 12);
        check_val("b10_error", error_cnt - e0, 1);
        check_val("b10_ready", ready_cnt - r0, 1);
        check_val("b10_input", bus.Input, 9);

        // Reset at edge 5 of a valid press
        r0 = ready_cnt; e0 = error_cnt;
        bus.Switches = 4'd8;
        bus.Button   = 1'b1;
        step(4);
        check_val("t6_busy_pre", bus.Busy, 1);
        rst = 1'b1;
        step(1);
        check_val("t6_input", bus.Input, 0);
        check_val("t6_ready", bus.Ready, 0);
        check_val("t6_error", bus.Error, 0);
        check_val("t6_busy",  bus.Busy,  0);
        rst = 1'b0;
        bus.Button = 1'b0;
        step(12);
        check_val("t6_ready_none", ready_cnt - r0, 0);
        check_val("t6_error_none", error_cnt - e0, 0);

        check_val("never_both", both_cnt, 0);
        check_val("one_cycle_wide", wide_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
